// File: rtl/fft_frame_sequencer.sv
// Frame controller between the ADC sample stream and the FFT core: fills a two-bank
// sample store at bit-reversed addresses and bursts each full bank into the core.
module fft_frame_sequencer #(
    parameter int ADC_DATLEN    = 12,
    parameter int FFT_VLEN      = 16,
    parameter int FFT_VLEN_LOG2 = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      smp_valid,
    input  logic [ADC_DATLEN-1:0]     smp_data,
    output logic                      wr_en,
    output logic                      wr_bank,
    output logic [FFT_VLEN_LOG2-1:0]  wr_addr,
    output logic [ADC_DATLEN-1:0]     wr_data,
    output logic                      rd_bank,
    output logic [FFT_VLEN_LOG2-1:0]  rd_addr,
    input  logic [ADC_DATLEN-1:0]     rd_data,
    output logic [2*ADC_DATLEN-1:0]   fft_in_x,
    output logic                      fft_in_nd,
    input  logic                      fft_out_nd,
    input  logic                      fft_overflow,
    output logic                      bin_valid,
    output logic [FFT_VLEN_LOG2-1:0]  bin_idx,
    output logic                      frame_done,
    output logic                      frame_err,
    output logic                      ovf_flag,
    output logic [7:0]                drop_cnt,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, FEED, WAIT, DRAIN} state_t;

    localparam logic [FFT_VLEN_LOG2-1:0] LAST = FFT_VLEN_LOG2'(FFT_VLEN - 1);

    state_t                   state;
    logic [FFT_VLEN_LOG2-1:0] wcnt;
    logic                     fill_bank;
    logic [1:0]               full;
    logic                     feed_d1;
    logic                     accept;
    logic                     fill_last;
    logic                     release_bank;
    logic                     unused_rd_lsb;

    function automatic logic [FFT_VLEN_LOG2-1:0] bitrev(input logic [FFT_VLEN_LOG2-1:0] v);
        logic [FFT_VLEN_LOG2-1:0] r;
        r = '0;
        for (int i = 0; i < FFT_VLEN_LOG2; i++) begin
            r[i] = v[FFT_VLEN_LOG2-1-i];
        end
        return r;
    endfunction

    // Both sides look at the registered full flags, so a sample arriving in the
    // release cycle of its bank is still dropped.
    assign accept        = smp_valid && !full[fill_bank];
    assign fill_last     = accept && (wcnt == LAST);
    assign release_bank  = (state == FEED) && (rd_addr == LAST);
    assign busy          = (state != IDLE);
    assign unused_rd_lsb = rd_data[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en     <= 1'b0;
            wr_bank   <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wcnt      <= '0;
            fill_bank <= 1'b0;
            drop_cnt  <= 8'd0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_bank <= fill_bank;
                wr_addr <= bitrev(wcnt);
                wr_data <= smp_data;
                wcnt    <= wcnt + 1'b1;
                if (wcnt == LAST) begin
                    fill_bank <= ~fill_bank;
                end
            end
            if (smp_valid && full[fill_bank] && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Fill and release always target different banks, so both may land together.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            if (fill_last) begin
                full[fill_bank] <= 1'b1;
            end
            if (release_bank) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_bank    <= 1'b0;
            rd_addr    <= '0;
            bin_valid  <= 1'b0;
            bin_idx    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        rd_addr <= '0;
                        state   <= FEED;
                    end
                end
                FEED: begin
                    if (rd_addr == LAST) begin
                        rd_bank <= ~rd_bank;
                        state   <= WAIT;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                WAIT: begin
                    if (fft_out_nd) begin
                        bin_valid <= 1'b1;
                        bin_idx   <= '0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bin_idx == LAST) begin
                        bin_valid  <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else if (fft_out_nd) begin
                        bin_idx <= bin_idx + 1'b1;
                    end else begin
                        bin_valid <= 1'b0;
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage feed pipeline: address cycle, store read cycle, then the core word.
    always_ff @(posedge clk) begin
        if (rst) begin
            feed_d1   <= 1'b0;
            fft_in_nd <= 1'b0;
            fft_in_x  <= '0;
            ovf_flag  <= 1'b0;
        end else begin
            feed_d1   <= (state == FEED);
            fft_in_nd <= feed_d1;
            fft_in_x  <= feed_d1 ? {1'b0, rd_data[ADC_DATLEN-1:1], {ADC_DATLEN{1'b0}}} : '0;
            if (fft_overflow) begin
                ovf_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer with a behavioural sample store and
// FFT core model; write, core-input and bin streams are checked through queues.
module tb_fft_frame_sequencer;

    localparam int W = 12;
    localparam int N = 16;
    localparam int L = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           smp_valid;
    logic [W-1:0]   smp_data;
    logic           wr_en;
    logic           wr_bank;
    logic [L-1:0]   wr_addr;
    logic [W-1:0]   wr_data;
    logic           rd_bank;
    logic [L-1:0]   rd_addr;
    logic [W-1:0]   rd_data;
    logic [2*W-1:0] fft_in_x;
    logic           fft_in_nd;
    logic           fft_out_nd;
    logic           fft_overflow;
    logic           bin_valid;
    logic [L-1:0]   bin_idx;
    logic           frame_done;
    logic           frame_err;
    logic           ovf_flag;
    logic [7:0]     drop_cnt;
    logic           busy;

    fft_frame_sequencer #(.ADC_DATLEN(W), .FFT_VLEN(N), .FFT_VLEN_LOG2(L)) dut (
        .clk(clk), .rst(rst), .smp_valid(smp_valid), .smp_data(smp_data),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data),
        .fft_in_x(fft_in_x), .fft_in_nd(fft_in_nd), .fft_out_nd(fft_out_nd),
        .fft_overflow(fft_overflow), .bin_valid(bin_valid), .bin_idx(bin_idx),
        .frame_done(frame_done), .frame_err(frame_err), .ovf_flag(ovf_flag),
        .drop_cnt(drop_cnt), .busy(busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- sample store model (registered read) ----------------
    logic [W-1:0] mem [2][N];
    always @(posedge clk) begin
        if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
        rd_data <= mem[rd_bank][rd_addr];
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [W+L:0]   wr_q[$];
    logic [2*W-1:0] fft_q[$];
    logic [L-1:0]   bin_q[$];
    logic [L-1:0]   rev_tbl [N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    logic [W-1:0]   cur [N];
    int             acc_cnt = 0;
    logic           acc_bank = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // An accepted sample: expected store write now, and once a bank is complete the
    // 16 core words it must produce (address k holds sample bitrev(k)).
    task automatic accept(input logic [W-1:0] d, input logic [L-1:0] addr);
        cur[acc_cnt] = d;
        wr_q.push_back({acc_bank, addr, d});
        acc_cnt++;
        if (acc_cnt == N) begin
            for (int k = 0; k < N; k++) begin
                fft_q.push_back({1'b0, cur[rev_tbl[k]][W-1:1], {W{1'b0}}});
            end
            acc_cnt = 0;
            acc_bank = ~acc_bank;
        end
    endtask

    logic prev_last = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (wr_en) begin
                if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
                else check("wr_txn", {wr_bank, wr_addr, wr_data}, wr_q.pop_front());
            end
            if (fft_in_nd) begin
                if (fft_q.size() == 0) check("fft_in_unexpected", 1, 0);
                else check("fft_in_x", fft_in_x, fft_q.pop_front());
            end
            if (bin_valid) begin
                if (bin_q.size() == 0) check("bin_unexpected", 1, 0);
                else check("bin_idx", bin_idx, bin_q.pop_front());
            end
            if (frame_done) begin
                done_cnt++;
                check("done_after_last_bin", prev_last, 1);
            end
            if (frame_err) err_cnt++;
            prev_last = bin_valid && (bin_idx == L'(N - 1));
        end
    end

    // ---------------- FFT core model ----------------
    int nd_seen = 0;
    int burst_no = 0;
    int ovf_at = -1;
    int core_lat = 3;
    int core_bins = N;

    task automatic core_burst();
        if (burst_no == ovf_at) begin
            @(posedge clk); #1 fft_overflow = 1'b1;
            @(posedge clk); #1 fft_overflow = 1'b0;
        end
        burst_no++;
        repeat (core_lat) @(posedge clk);
        for (int b = 0; b < core_bins; b++) begin
            @(posedge clk); #1 fft_out_nd = 1'b1;
            bin_q.push_back(L'(b));
        end
        @(posedge clk); #1 fft_out_nd = 1'b0;
    endtask

    initial begin
        fft_out_nd = 1'b0;
        fft_overflow = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) nd_seen = 0;
            else if (fft_in_nd) begin
                nd_seen++;
                if (nd_seen == N) begin
                    nd_seen = 0;
                    core_burst();
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] d, input bit acc);
        @(posedge clk); #1;
        smp_valid = 1'b1;
        smp_data = d;
        if (acc) accept(d, rev_tbl[acc_cnt]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            smp_valid = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {wr_en, wr_bank, wr_addr, rd_bank, rd_addr, fft_in_nd, bin_valid,
                              bin_idx, frame_done, frame_err, ovf_flag, busy}, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_fft_in_x"}, fft_in_x, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
    endtask

    task automatic wait_idle(input int want_done, input int want_err, input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done_cnt == want_done && err_cnt == want_err && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_reached_idle"}, ok, 1);
        check({tag, "_done_cnt"}, done_cnt, want_done);
        check({tag, "_err_cnt"}, err_cnt, want_err);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_bins_left"}, bin_q.size(), 0);
        check({tag, "_fft_left"}, fft_q.size(), 0);
        check({tag, "_wr_left"}, wr_q.size(), 0);
    endtask

    // ---------------- test ----------------
    typedef struct {
        logic [W-1:0] data;
        logic [L-1:0] exp_addr;
    } vec_t;

    vec_t tbl [N];
    logic [W-1:0] d;
    int lat;
    int run;
    int nd_after;

    initial begin
        for (int k = 0; k < N; k++) begin
            tbl[k].data = W'(k * 273 + 17);
            tbl[k].exp_addr = rev_tbl[k];
        end

        rst = 1'b1;
        smp_valid = 1'b0;
        smp_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");

        // Frame 1: table-driven fill of bank 0, then latency and contiguity of the feed.
        core_lat = 3;
        core_bins = N;
        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            smp_valid = 1'b1;
            smp_data = tbl[k].data;
            accept(tbl[k].data, tbl[k].exp_addr);
        end
        @(posedge clk); #1 smp_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (fft_in_nd) begin
                lat = n;
                break;
            end
            @(posedge clk);
        end
        check("first_nd_latency", lat, 4);
        run = 1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (fft_in_nd) run++;
            else break;
        end
        check("nd_run_length", run, N);
        check("busy_after_feed", busy, 1);
        wait_idle(1, 0, "frame1");

        // Continuous stream with a slow core: sample 32 lands in bank 1's release cycle
        // and is dropped; samples 49..63 find both banks full.
        core_lat = 40;
        for (int i = 0; i < 64; i++) begin
            d = W'($urandom_range(0, 4095));
            send(d, (i < 32) || (i >= 33 && i <= 48));
        end
        idle(1);
        @(negedge clk);
        check("drop_cnt_stream", drop_cnt, 16);
        wait_idle(4, 0, "stream");

        // Core output truncated after 9 bins.
        core_lat = 2;
        core_bins = 9;
        for (int i = 0; i < N; i++) send(W'($urandom_range(0, 4095)), 1'b1);
        idle(1);
        wait_idle(4, 1, "truncated");
        core_bins = N;

        // Overflow in WAIT, then saturate the drop counter while the core stalls.
        @(negedge clk);
        check("ovf_clear_before", ovf_flag, 0);
        core_lat = 450;
        ovf_at = burst_no;
        for (int i = 0; i < N; i++) send(W'($urandom_range(0, 4095)), 1'b1);
        idle(25);
        for (int i = 0; i < 2 * N; i++) send(W'($urandom_range(0, 4095)), 1'b1);
        idle(1);
        @(negedge clk);
        check("drop_cnt_before_sat", drop_cnt, 16);
        for (int i = 0; i < 238; i++) send(W'($urandom_range(0, 4095)), 1'b0);
        idle(1);
        @(negedge clk);
        check("drop_cnt_254", drop_cnt, 254);
        send(W'($urandom_range(0, 4095)), 1'b0);
        idle(1);
        @(negedge clk);
        check("drop_cnt_255", drop_cnt, 255);
        for (int i = 0; i < 61; i++) send(W'($urandom_range(0, 4095)), 1'b0);
        idle(1);
        @(negedge clk);
        check("drop_cnt_saturated", drop_cnt, 255);
        check("ovf_set", ovf_flag, 1);
        core_lat = 3;
        wait_idle(7, 1, "overflow");
        check("ovf_sticky", ovf_flag, 1);

        // Reset while rd_addr = 7 is presented: 16th strobe at S, rd_addr = 7 at S+9.
        for (int i = 0; i < N; i++) send(W'($urandom_range(0, 4095)), 1'b1);
        @(posedge clk); #1 smp_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_at_rd_addr", rd_addr, 7);
        check("rst_in_feed_busy", busy, 1);
        check("rst_in_feed_nd", fft_in_nd, 1);
        @(posedge clk); #1 rst = 1'b0;
        fft_q.delete();
        acc_cnt = 0;
        acc_bank = 1'b0;
        @(negedge clk);
        check_all_zero("mid_frame_reset");
        nd_after = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (fft_in_nd) nd_after++;
        end
        check("no_feed_after_reset", nd_after, 0);
        check("wr_q_after_reset", wr_q.size(), 0);

        // Fresh fill after reset starts in bank 0 at address 0.
        for (int i = 0; i < N; i++) send(W'($urandom_range(0, 4095)), 1'b1);
        idle(1);
        wait_idle(8, 1, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
